// File: rtl/trace_pkg.sv
// Shared types and constants for the trace capture block.
package trace_pkg;

    localparam int TRACE_REC_W = 96;

    typedef enum logic [1:0] {
        WORD_PC  = 2'd0,
        WORD_ALU = 2'd1,
        WORD_MEM = 2'd2
    } word_state_t;

endpackage

// File: rtl/trace_fifo.sv
// Synchronous record FIFO with a combinational head; the push is also accepted when full if a pop occurs on the same edge.
import trace_pkg::*;

module trace_fifo #(
    parameter int DEPTH_LOG2 = 3
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   push,
    input  logic [TRACE_REC_W-1:0] wr_data,
    input  logic                   pop,
    output logic [TRACE_REC_W-1:0] rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [DEPTH_LOG2:0]    count
);

    localparam logic [DEPTH_LOG2:0] DEPTH = (DEPTH_LOG2 + 1)'(1 << DEPTH_LOG2);

    logic [TRACE_REC_W-1:0] mem [2**DEPTH_LOG2];
    logic [DEPTH_LOG2-1:0]  wr_ptr;
    logic [DEPTH_LOG2-1:0]  rd_ptr;
    logic                   do_push;
    logic                   do_pop;

    assign full    = (count == DEPTH);
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rd_data = mem[rd_ptr];

    // Storage has no reset: a reset only rewinds pointers and count.
    always_ff @(posedge clock) begin
        if (do_push && !reset) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/trace_capture.sv
// Captures {pc, alu, dmem} records into a FIFO and serializes each as three 32-bit words.
// Optional macro TRACE_PC_FILTER_EN suppresses captures whose PC repeats the last pushed record.
import trace_pkg::*;

module trace_capture #(
    parameter int DEPTH_LOG2 = 3
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  capture_en,
    input  logic [31:0]           pc_in,
    input  logic [31:0]           alu_in,
    input  logic [31:0]           dmem_in,
    output logic [31:0]           out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic                  overflow,
    output logic [DEPTH_LOG2:0]   count,
    output logic [1:0]            state
);

    // Handshake: a word transfers on a rising edge where out_valid && out_ready;
    // out_data/out_last hold while out_valid=1 and out_ready=0.

    word_state_t            state_q;
    word_state_t            state_d;
    logic [TRACE_REC_W-1:0] head;
    logic                   full;
    logic                   empty;
    logic                   eligible;
    logic                   pop;
    logic                   push;
    logic                   accept;

    assign out_valid = !empty;
    assign accept    = out_valid && out_ready;
    assign pop       = accept && (state_q == WORD_MEM);
    assign push      = capture_en && eligible && (!full || pop);
    assign state     = state_q;

`ifdef TRACE_PC_FILTER_EN
    logic [31:0] last_pc;
    logic        last_pc_valid;

    assign eligible = !last_pc_valid || (pc_in != last_pc);

    always_ff @(posedge clock) begin
        if (reset) begin
            last_pc       <= '0;
            last_pc_valid <= 1'b0;
        end else if (push) begin
            last_pc       <= pc_in;
            last_pc_valid <= 1'b1;
        end
    end
`else
    assign eligible = 1'b1;
`endif

    trace_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .push    (push),
        .wr_data ({pc_in, alu_in, dmem_in}),
        .pop     (pop),
        .rd_data (head),
        .full    (full),
        .empty   (empty),
        .count   (count)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (capture_en && eligible && full && !pop) begin
            overflow <= 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) state_q <= WORD_PC;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (accept) begin
            case (state_q)
                WORD_PC:  state_d = WORD_ALU;
                WORD_ALU: state_d = WORD_MEM;
                default:  state_d = WORD_PC;
            endcase
        end
    end

    // Head memory is never cleared, so mask the word when nothing is stored.
    always_comb begin
        out_data = '0;
        out_last = 1'b0;
        if (!empty) begin
            case (state_q)
                WORD_PC:  out_data = head[95:64];
                WORD_ALU: out_data = head[63:32];
                default: begin
                    out_data = head[31:0];
                    out_last = 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_trace_capture.sv
// Directed bench for trace_capture: reset, single record, overflow, full push+pop, stall, filter, mid-record reset.
module tb_trace_capture;

    logic        clock = 1'b0;
    logic        reset;
    logic        capture_en;
    logic [31:0] pc_in;
    logic [31:0] alu_in;
    logic [31:0] dmem_in;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic        overflow;
    logic [3:0]  count;
    logic [1:0]  state;

    int checks = 0;
    int fails  = 0;
    logic [31:0] exp_q[$];

    always #5 clock = ~clock;

    trace_capture #(.DEPTH_LOG2(3)) dut (
        .clock      (clock),
        .reset      (reset),
        .capture_en (capture_en),
        .pc_in      (pc_in),
        .alu_in     (alu_in),
        .dmem_in    (dmem_in),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last),
        .overflow   (overflow),
        .count      (count),
        .state      (state)
    );

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        capture_en = 1'b0;
        out_ready = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic set_rec(input logic [31:0] p, input logic [31:0] a, input logic [31:0] d);
        pc_in = p;
        alu_in = a;
        dmem_in = d;
    endtask

    task automatic test_reset();
        pc_in = '0; alu_in = '0; dmem_in = '0;
        do_reset();
        checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %0b want 0", out_valid); end
        checks++; if (out_last !== 1'b0) begin fails++; $display("FAIL reset_last got %0b want 0", out_last); end
        checks++; if (count !== 4'd0) begin fails++; $display("FAIL reset_count got %0d want 0", count); end
        checks++; if (overflow !== 1'b0) begin fails++; $display("FAIL reset_overflow got %0b want 0", overflow); end
        checks++; if (out_data !== 32'h0) begin fails++; $display("FAIL reset_data got %h want 0", out_data); end
        checks++; if (state !== 2'd0) begin fails++; $display("FAIL reset_state got %0d want 0", state); end
    endtask

    task automatic test_single();
        logic [31:0] w [3];
        w[0] = 32'h4; w[1] = 32'hA; w[2] = 32'h0;
        set_rec(32'h4, 32'hA, 32'h0);
        out_ready = 1'b1;
        capture_en = 1'b1;
        step();
        capture_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++; if (out_valid !== 1'b1) begin fails++; $display("FAIL single_valid%0d got %0b want 1", i, out_valid); end
            checks++; if (out_data !== w[i]) begin fails++; $display("FAIL single_word%0d got %h want %h", i, out_data, w[i]); end
            checks++; if (out_last !== (i == 2)) begin fails++; $display("FAIL single_last%0d got %0b want %0b", i, out_last, (i == 2)); end
            step();
        end
        checks++; if (count !== 4'd0) begin fails++; $display("FAIL single_count_end got %0d want 0", count); end
        checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL single_valid_end got %0b want 0", out_valid); end
    endtask

    task automatic test_overflow();
        do_reset();
        exp_q.delete();
        capture_en = 1'b1;
        for (int i = 0; i < 9; i++) begin
            set_rec(32'h100 + i, 32'h200 + i, 32'h300 + i);
            if (i < 8) begin
                exp_q.push_back(32'h100 + i);
                exp_q.push_back(32'h200 + i);
                exp_q.push_back(32'h300 + i);
            end
            step();
        end
        capture_en = 1'b0;
        checks++; if (count !== 4'd8) begin fails++; $display("FAIL ovf_count got %0d want 8", count); end
        checks++; if (overflow !== 1'b1) begin fails++; $display("FAIL ovf_flag got %0b want 1", overflow); end
        out_ready = 1'b1;
        for (int k = 0; k < 24; k++) begin
            logic [31:0] e;
            e = exp_q.pop_front();
            checks++; if (out_valid !== 1'b1 || out_data !== e) begin fails++; $display("FAIL ovf_drain%0d got %h/%0b want %h/1", k, out_data, out_valid, e); end
            checks++; if (out_last !== ((k % 3) == 2)) begin fails++; $display("FAIL ovf_last%0d got %0b want %0b", k, out_last, ((k % 3) == 2)); end
            step();
        end
        checks++; if (count !== 4'd0) begin fails++; $display("FAIL ovf_count_end got %0d want 0", count); end
        checks++; if (overflow !== 1'b1) begin fails++; $display("FAIL ovf_sticky got %0b want 1", overflow); end
    endtask

    task automatic test_full_pop();
        do_reset();
        capture_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            set_rec(32'h500 + i, 32'h600 + i, 32'h700 + i);
            step();
        end
        capture_en = 1'b0;
        out_ready = 1'b1;
        step();
        step();
        checks++; if (out_last !== 1'b1) begin fails++; $display("FAIL fp_at_mem got %0b want 1", out_last); end
        set_rec(32'h5FF, 32'h6FF, 32'h7FF);
        capture_en = 1'b1;
        step();
        capture_en = 1'b0;
        out_ready = 1'b0;
        checks++; if (count !== 4'd8) begin fails++; $display("FAIL fp_count got %0d want 8", count); end
        checks++; if (overflow !== 1'b0) begin fails++; $display("FAIL fp_overflow got %0b want 0", overflow); end
        checks++; if (out_data !== 32'h501) begin fails++; $display("FAIL fp_head got %h want 501", out_data); end
        out_ready = 1'b1;
        for (int i = 0; i < 21; i++) step();
        checks++; if (out_data !== 32'h5FF) begin fails++; $display("FAIL fp_tail got %h want 5ff", out_data); end
        checks++; if (count !== 4'd1) begin fails++; $display("FAIL fp_tail_count got %0d want 1", count); end
    endtask

    task automatic test_stall();
        logic pat [6];
        logic [31:0] held;
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        do_reset();
        exp_q.delete();
        set_rec(32'hAAA0, 32'hBBB0, 32'hCCC0);
        exp_q.push_back(32'hAAA0); exp_q.push_back(32'hBBB0); exp_q.push_back(32'hCCC0);
        capture_en = 1'b1;
        step();
        capture_en = 1'b0;
        held = 32'h0;
        for (int i = 0; i < 6; i++) begin
            out_ready = pat[i];
            #1;
            if (i > 0 && !pat[i - 1]) begin
                checks++; if (out_data !== held) begin fails++; $display("FAIL stall_hold%0d got %h want %h", i, out_data, held); end
            end
            if (pat[i] && exp_q.size() > 0) begin
                logic [31:0] e;
                e = exp_q.pop_front();
                checks++; if (out_valid !== 1'b1 || out_data !== e) begin fails++; $display("FAIL stall_word%0d got %h want %h", i, out_data, e); end
            end
            held = out_data;
            step();
        end
        checks++; if (exp_q.size() != 0 || count !== 4'd0) begin fails++; $display("FAIL stall_end count %0d left %0d want 0 0", count, exp_q.size()); end
    endtask

    task automatic test_filter();
        logic [3:0] want;
`ifdef TRACE_PC_FILTER_EN
        want = 4'd2;
`else
        want = 4'd6;
`endif
        do_reset();
        capture_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            set_rec((i < 5) ? 32'h20 : 32'h24, 32'h40 + i, 32'h80 + i);
            step();
        end
        capture_en = 1'b0;
        checks++; if (count !== want) begin fails++; $display("FAIL filter_count got %0d want %0d", count, want); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        capture_en = 1'b1;
        set_rec(32'h11, 32'h22, 32'h33); step();
        set_rec(32'h44, 32'h55, 32'h66); step();
        capture_en = 1'b0;
        out_ready = 1'b1;
        step();
        step();
        checks++; if (state !== 2'd2) begin fails++; $display("FAIL mid_pre_state got %0d want 2", state); end
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL mid_valid got %0b want 0", out_valid); end
        checks++; if (count !== 4'd0) begin fails++; $display("FAIL mid_count got %0d want 0", count); end
        checks++; if (state !== 2'd0) begin fails++; $display("FAIL mid_state got %0d want 0", state); end
        checks++; if (out_data !== 32'h0) begin fails++; $display("FAIL mid_data got %h want 0", out_data); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_overflow();
        test_full_pop();
        test_stall();
        test_filter();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/trace_capture.md
TRACE_CAPTURE -- requirements
Module: trace_capture

Interface
REQ-001 Parameter DEPTH_LOG2, default 3, log2 of FIFO depth in records (8 records).
REQ-002 clock  input  1  rising-edge clock, shared with the monocycle core.
REQ-003 reset  input  1  reset, synchronous and active-high.
REQ-004 capture_en  input  1  high: sample this cycle's core outputs.
REQ-005 pc_in  input  32  core PC_out.
REQ-006 alu_in  input  32  core ALU_out.
REQ-007 dmem_in  input  32  core d_mem_out.
REQ-008 out_data  output  32  current serialized trace word.
REQ-009 out_valid  output  1  out_data is valid.
REQ-010 out_ready  input  1  consumer accepts out_data.
REQ-011 out_last  output  1  out_data is the last word of a record.
REQ-012 overflow  output  1  sticky flag: a record was dropped.
REQ-013 count  output  DEPTH_LOG2+1  records currently stored.

Function
REQ-014 A record is {pc_in, alu_in, dmem_in}, 96 bits, captured at the rising edge where capture_en=1 and a push is permitted.
REQ-015 The FIFO holds 2^DEPTH_LOG2 records; pointers wrap modulo depth; count ranges 0..2^DEPTH_LOG2.
REQ-016 A record pushed at edge N drives out_valid=1 from cycle N+1 (one-cycle latency) when the FIFO was empty.
REQ-017 out_valid = (count != 0); out_data comes combinationally from the head record, selected by the serializer state.
REQ-018 Serializer FSM states WORD_PC -> WORD_ALU -> WORD_MEM -> WORD_PC; it advances only on an edge with out_valid && out_ready.
REQ-019 out_data: WORD_PC=pc, WORD_ALU=alu, WORD_MEM=dmem; out_last=1 only in WORD_MEM.
REQ-020 The head record is popped on the edge where WORD_MEM is accepted; a record takes a minimum of 3 cycles to drain.
REQ-021 out_data and out_last stay stable while out_valid=1 and out_ready=0.
REQ-022 A push while full is permitted only when a pop occurs the same edge; count is then unchanged.
REQ-023 A push while full without a simultaneous pop drops the record and sets overflow=1; overflow is cleared only by reset.
REQ-024 A simultaneous push and pop at any count leaves count unchanged and advances both pointers.
REQ-025 With out_valid=0, the FSM holds WORD_PC and out_ready is ignored.

Reset
REQ-026 While reset=1 at an edge: pointers=0, count=0, FSM=WORD_PC, overflow=0, filter state cleared; no push occurs.
REQ-027 After reset: out_valid=0, out_last=0, count=0, overflow=0; out_data=0 while count=0.
REQ-028 Reset mid-record discards all stored records, including the partially drained one; storage contents are not cleared.

Configuration
REQ-029 Macro TRACE_PC_FILTER_EN: when defined, a push additionally requires pc_in != the PC of the last pushed record.
REQ-030 The first capture after reset is always eligible; a dropped (overflow) record does not update the stored last PC.
REQ-031 Without TRACE_PC_FILTER_EN, every capture_en cycle is eligible and no last-PC register exists.

Structure
REQ-032 Package trace_pkg holds the serializer state typedef (WORD_PC=0, WORD_ALU=1, WORD_MEM=2) and constant TRACE_REC_W=96.
REQ-033 Sub-module trace_fifo: synchronous FIFO with width TRACE_REC_W and depth parameter; it exposes full, empty and count.
REQ-034 The serializer FSM, overflow flag and filter logic live in trace_capture.

Verification
REQ-035 Reset, then one capture of pc=0x00000004, alu=0x0000000A, dmem=0x00000000 with out_ready=1 -> out_valid rises the next cycle; words 0x4, 0xA, 0x0 appear on consecutive cycles; out_last is high on the third; count returns to 0.
REQ-036 Capture 8 records with out_ready=0, then a 9th -> count=8, overflow=1; drain -> 24 words equal to the first 8 records, in order.
REQ-037 Full FIFO with WORD_MEM accepted on the same edge as a capture -> count stays 8, overflow stays 0.
REQ-038 Toggle out_ready 1,0,0,1 during a record -> out_data is held stable while out_ready=0; no words are lost or duplicated.
REQ-039 With TRACE_PC_FILTER_EN defined, pc_in=0x20 for 5 cycles, then 0x24 -> exactly 2 records are stored. Without the macro -> 6 records are stored.
REQ-040 Assert reset after the WORD_ALU word is accepted -> next cycle out_valid=0, count=0, FSM=WORD_PC.
